// File: rtl/vmem_arbiter.sv
// Video-memory port arbiter: scan-out reads have priority, writer pixels queue in
// a FIFO and drain on idle cycles, with a starvation counter that steals one read slot.
module vmem_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STARVE_LIMIT = 1024,
  parameter int unsigned DATA_W       = 24
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rd_req,
  input  logic [9:0]                    rd_h_addr,
  input  logic [8:0]                    rd_v_addr,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_stolen,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [9:0]                    wr_h_addr,
  input  logic [8:0]                    wr_v_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [18:0]                   mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [9:0]        h;
    logic [8:0]        v;
    logic [DATA_W-1:0] d;
  } wr_entry_t;

  wr_entry_t         fifo_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rdy_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              s1_gnt_q, s1_stl_q;
  logic              rd_valid_q, rd_stolen_q;
  logic [DATA_W-1:0] rd_data_q;

  logic      push, pop, fifo_ne, force_c, gnt_rd, stolen;
  wr_entry_t head;

  assign head    = fifo_q[rd_ptr_q];
  assign fifo_ne = (count_q != '0);
  assign force_c = fifo_ne && (starve_q >= SW'(STARVE_LIMIT));
  assign push    = wr_valid && rdy_q;

  // Grant decision; resetn gates every access so a held reset keeps the port quiet.
  always_comb begin
    pop       = 1'b0;
    gnt_rd    = 1'b0;
    stolen    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (resetn) begin
      if (fifo_ne && (!rd_req || force_c)) begin
        pop       = 1'b1;
        stolen    = rd_req;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {head.h, head.v};
        mem_wdata = head.d;
      end else if (rd_req) begin
        gnt_rd   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {rd_h_addr, rd_v_addr};
      end
    end
  end

  // FIFO pointer/occupancy and starvation counter next state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    starve_d = starve_q;
    if (!fifo_ne || pop)                      starve_d = '0;
    else if (starve_q < SW'(STARVE_LIMIT))    starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdy_q       <= 1'b0;
      starve_q    <= '0;
      s1_gnt_q    <= 1'b0;
      s1_stl_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_stolen_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdy_q       <= (count_d < CW'(FIFO_DEPTH));
      starve_q    <= starve_d;
      s1_gnt_q    <= gnt_rd;
      s1_stl_q    <= stolen;
      rd_valid_q  <= s1_gnt_q;
      rd_stolen_q <= s1_stl_q;
      if (s1_gnt_q) rd_data_q <= mem_rdata;
    end
  end

  // Entry storage needs no reset; occupancy tracking decides what is live.
  always_ff @(posedge clk) begin
    if (resetn && push) fifo_q[wr_ptr_q] <= '{h: wr_h_addr, v: wr_v_addr, d: wr_data};
  end

  assign wr_ready   = rdy_q;
  assign fifo_count = count_q;
  assign rd_valid   = rd_valid_q;
  assign rd_stolen  = rd_stolen_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter: one default instance plus one with a short starvation limit.
module tb_vmem_arbiter;

  logic        clk, resetn, rd_req, wr_valid;
  logic [9:0]  rd_h_addr, wr_h_addr;
  logic [8:0]  rd_v_addr, wr_v_addr;
  logic [23:0] wr_data;

  logic        rd_valid, rd_stolen, wr_ready, mem_en, mem_we;
  logic [23:0] rd_data, mem_wdata, mem_rdata;
  logic [18:0] mem_addr;
  logic [3:0]  fifo_count;

  logic        s_rd_valid, s_rd_stolen, s_wr_ready, s_mem_en, s_mem_we;
  logic [23:0] s_rd_data, s_mem_wdata, s_mem_rdata;
  logic [18:0] s_mem_addr;
  logic [3:0]  s_fifo_count;

  int n_chk  = 0;
  int n_fail = 0;

  vmem_arbiter u_dut (
    .clk(clk), .resetn(resetn), .rd_req(rd_req), .rd_h_addr(rd_h_addr), .rd_v_addr(rd_v_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_stolen(rd_stolen),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_h_addr(wr_h_addr), .wr_v_addr(wr_v_addr),
    .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fifo_count(fifo_count)
  );

  vmem_arbiter #(.STARVE_LIMIT(4)) u_dut_s (
    .clk(clk), .resetn(resetn), .rd_req(rd_req), .rd_h_addr(rd_h_addr), .rd_v_addr(rd_v_addr),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_stolen(s_rd_stolen),
    .wr_valid(wr_valid), .wr_ready(s_wr_ready), .wr_h_addr(wr_h_addr), .wr_v_addr(wr_v_addr),
    .wr_data(wr_data), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .fifo_count(s_fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory models; unwritten locations read back as {5'b0, addr}.
  logic [23:0] mem_a [logic [18:0]];
  always @(posedge clk) begin
    if (mem_en && !mem_we)
      mem_rdata <= mem_a.exists(mem_addr) ? mem_a[mem_addr] : {5'd0, mem_addr};
    if (mem_en && mem_we) mem_a[mem_addr] = mem_wdata;
  end
  always @(posedge clk) begin
    if (s_mem_en && !s_mem_we) s_mem_rdata <= {5'd0, s_mem_addr};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    resetn = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  int we_seen;

  initial begin
    mem_a[19'h0202] = 24'h123456;
    resetn = 1'b0; rd_req = 1'b1; wr_valid = 1'b1;
    rd_h_addr = 10'd1; rd_v_addr = 9'd2;
    wr_h_addr = 10'd7; wr_v_addr = 9'd7; wr_data = 24'h999999;

    // Reset held two cycles with both requesters active
    tick();
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_stolen", rd_stolen, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_rd_data", rd_data, 0);
    tick();
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_s_mem_en", s_mem_en, 0);
    resetn = 1'b1; rd_req = 1'b0; wr_valid = 1'b0;
    tick();
    check_eq("rel_wr_ready", wr_ready, 1);
    check_eq("rel_count", fifo_count, 0);

    // Idle write
    wr_valid = 1'b1; wr_h_addr = 10'd5; wr_v_addr = 9'd3; wr_data = 24'hABCDEF;
    #1 check_eq("nowt_mem_en", mem_en, 0);
    tick();
    wr_valid = 1'b0;
    #1;
    check_eq("iw_mem_en", mem_en, 1);
    check_eq("iw_mem_we", mem_we, 1);
    check_eq("iw_addr", mem_addr, 19'h0A03);
    check_eq("iw_wdata", mem_wdata, 24'hABCDEF);
    check_eq("iw_count1", fifo_count, 1);
    tick();
    check_eq("iw_count0", fifo_count, 0);

    // Read latency
    rd_req = 1'b1; rd_h_addr = 10'd1; rd_v_addr = 9'd2;
    #1;
    check_eq("rd_addr", mem_addr, 19'h0202);
    check_eq("rd_we", mem_we, 0);
    check_eq("rd_en", mem_en, 1);
    tick();
    rd_req = 1'b0;
    #1 check_eq("rd_valid_t1", rd_valid, 0);
    tick();
    check_eq("rd_valid_t2", rd_valid, 1);
    check_eq("rd_data_t2", rd_data, 24'h123456);

    // Read after write sees the written pixel
    rd_req = 1'b1; rd_h_addr = 10'd5; rd_v_addr = 9'd3;
    tick();
    rd_req = 1'b0;
    tick();
    check_eq("coh_data", rd_data, 24'hABCDEF);

    // Simultaneous push and pop
    wr_valid = 1'b1; wr_h_addr = 10'd3; wr_v_addr = 9'd3; wr_data = 24'h111111;
    tick();
    wr_h_addr = 10'd4; wr_v_addr = 9'd4; wr_data = 24'h222222;
    #1;
    check_eq("pp_addr1", mem_addr, 19'h0603);
    check_eq("pp_count_a", fifo_count, 1);
    tick();
    wr_valid = 1'b0;
    #1;
    check_eq("pp_count_b", fifo_count, 1);
    check_eq("pp_addr2", mem_addr, 19'h0804);
    check_eq("pp_wdata2", mem_wdata, 24'h222222);
    tick();
    check_eq("pp_count_c", fifo_count, 0);

    // Full FIFO under continuous reads
    rd_req = 1'b1; rd_h_addr = 10'd0; rd_v_addr = 9'd0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_h_addr = 10'(16 + i); wr_v_addr = 9'(i); wr_data = 24'(256 + i);
      #1;
      check_eq("full_accept", wr_ready, 1);
      check_eq("full_no_we", mem_we, 0);
      tick();
    end
    wr_h_addr = 10'd31; wr_v_addr = 9'd8; wr_data = 24'h000108;
    #1;
    check_eq("full_ready0", wr_ready, 0);
    check_eq("full_count8", fifo_count, 8);
    we_seen = 0;
    for (int c = 7; c < 1024; c++) begin
      if (c == 12) wr_valid = 1'b0;
      #1;
      if (c == 11) check_eq("full_held", fifo_count, 8);
      if (mem_we) we_seen++;
      tick();
    end
    check_eq("full_we_seen", we_seen, 0);
    #1;
    check_eq("full_forced_we", mem_we, 1);
    check_eq("full_forced_addr", mem_addr, 19'h02000);

    // Starvation with limit 4
    reset_dut();
    rd_req = 1'b1; rd_h_addr = 10'd7; rd_v_addr = 9'd9;
    tick(); tick(); tick();
    wr_valid = 1'b1; wr_h_addr = 10'd2; wr_v_addr = 9'd1; wr_data = 24'h55AA55;
    tick();
    wr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check_eq("st_read_we", s_mem_we, 0);
      check_eq("st_read_addr", s_mem_addr, 19'h00E09);
      tick();
    end
    #1;
    check_eq("st_force_we", s_mem_we, 1);
    check_eq("st_force_addr", s_mem_addr, 19'h00401);
    check_eq("st_force_wdata", s_mem_wdata, 24'h55AA55);
    tick();
    check_eq("st_t6_valid", s_rd_valid, 1);
    check_eq("st_t6_data", s_rd_data, 24'h000E09);
    tick();
    check_eq("st_t7_stolen", s_rd_stolen, 1);
    check_eq("st_t7_valid", s_rd_valid, 0);
    check_eq("st_t7_data", s_rd_data, 24'h000E09);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("st_after_valid", s_rd_valid, 1);
      check_eq("st_after_stolen", s_rd_stolen, 0);
      check_eq("st_after_we", s_mem_we, 0);
    end

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_h_addr = 10'(20 + i); wr_v_addr = 9'(i); wr_data = 24'(4096 + i);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    check_eq("mr_pre_count", fifo_count, 4);
    check_eq("mr_pre_valid", rd_valid, 1);
    resetn = 1'b0; rd_req = 1'b0;
    #1 check_eq("mr_gate_en", mem_en, 0);
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("mr_we", mem_we, 0);
      check_eq("mr_valid", rd_valid, 0);
      check_eq("mr_stolen", rd_stolen, 0);
      check_eq("mr_count", fifo_count, 0);
      tick();
    end
    wr_valid = 1'b1; wr_h_addr = 10'd9; wr_v_addr = 9'd4; wr_data = 24'h777777;
    tick();
    wr_valid = 1'b0;
    #1;
    check_eq("mr_post_we", mem_we, 1);
    check_eq("mr_post_addr", mem_addr, 19'h01204);
    check_eq("mr_post_wdata", mem_wdata, 24'h777777);
    check_eq("mr_post_count", fifo_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
Shares the single video-memory port between two requesters. The VGA scan-out path issues reads every active pixel. A writer path (keyboard/terminal logic drawing into the framebuffer) issues pixel writes through an internal FIFO. Reads have priority. Buffered writes drain on idle cycles, and a starvation counter forces a write slot so writes cannot wait forever during long active-video stretches. The block sits between vga_ctrl/the writer and the vmem storage.

Parameters:
FIFO_DEPTH, 8, write-FIFO entries (power of two, ≥2)
STARVE_LIMIT, 1024, cycles a non-empty FIFO may go ungranted before one read slot is stolen
DATA_W, 24, pixel width (RGB888)

Ports:
clk  in  1  single clock
resetn  in  1  synchronous, active-low reset
rd_req  in  1  read request this cycle
rd_h_addr  in  10  read column
rd_v_addr  in  9  read row
rd_valid  out  1  rd_data valid; 2 cycles after the granted rd_req
rd_data  out  DATA_W  read pixel, registered
rd_stolen  out  1  pulse, 2 cycles after an rd_req whose slot was given to a write
wr_valid  in  1  writer offers an entry
wr_ready  out  1  FIFO can accept an entry
wr_h_addr  in  10  write column
wr_v_addr  in  9  write row
wr_data  in  DATA_W  write pixel
mem_en  out  1  memory access this cycle
mem_we  out  1  1 = write, 0 = read
mem_addr  out  19  {h_addr, v_addr}, matching the vmem layout
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  synchronous memory read data, 1 cycle after mem_en && !mem_we
fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (resetn=0 at a rising edge):
  - FIFO emptied; starve_cnt=0; read pipeline cleared.
  - All outputs 0, including wr_ready.
  - wr_ready becomes 1 on the first cycle after release.
  - Reset mid-operation discards queued writes and suppresses in-flight rd_valid/rd_stolen.
- Handshake:
  - A push occurs when wr_valid && wr_ready at a rising edge.
  - wr_ready = (fifo_count < FIFO_DEPTH), driven from registered state only.
  - A full FIFO is never written.
- Grant, decided combinationally each cycle from registered state:
  - force = FIFO non-empty && starve_cnt >= STARVE_LIMIT.
  - WRITE if FIFO non-empty && (!rd_req || force). Pops the head; mem_en=1, mem_we=1, mem_addr/mem_wdata taken from the head.
  - READ if rd_req && !force. mem_en=1, mem_we=0, mem_addr={rd_h_addr, rd_v_addr}.
  - IDLE otherwise: mem_en=0, mem_we=0, address/data don't-care (driven 0).
- No write-through: an entry pushed at edge t is first eligible for grant in cycle t+1.
- Simultaneous push and pop: both take effect, and fifo_count is unchanged.
- Read pipeline, 2-stage:
  - Stage 1 records (granted, stolen) for each rd_req cycle.
  - Stage 2 captures mem_rdata into rd_data when granted and sets rd_valid=1.
  - If stolen, rd_valid=0, rd_stolen=1, and rd_data holds its previous value.
  - Cycles with no rd_req give rd_valid=0 and rd_stolen=0.
- Starvation counter:
  - Cleared when the FIFO is empty or a WRITE is granted.
  - Otherwise increments each cycle, saturating at STARVE_LIMIT.
  - Exactly one write is forced per saturation; the counter restarts from 0.
- Coherence: a read granted in a cycle after a WRITE to the same address returns the new data. There is no forwarding from FIFO contents.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles with wr_valid=1 and rd_req=1.
   - During reset: all outputs 0 and no push.
   - Cycle after release: wr_ready=1, fifo_count=0.
2. Idle write: rd_req=0; push h=5, v=3, data=0xABCDEF at edge t.
   - t+1: mem_en=1, mem_we=1, mem_addr=0x0A03, mem_wdata=0xABCDEF, fifo_count=1.
   - t+2: fifo_count=0.
3. Read latency: rd_req with h=1, v=2 in cycle t; memory model returns 0x123456.
   - Cycle t: mem_addr=0x0202, mem_we=0.
   - t+2: rd_valid=1, rd_data=0x123456.
4. Full FIFO: rd_req held 1, STARVE_LIMIT=1024; offer 9 entries back-to-back.
   - 8 accepted; wr_ready=0 after the 8th.
   - 9th is held, not accepted; fifo_count=8.
   - No mem_we during the next 1023 cycles.
5. Starvation: STARVE_LIMIT=4, rd_req held 1; one entry pushed at edge t.
   - t+1..t+4: reads.
   - t+5: forced write.
   - t+7: rd_stolen=1, rd_valid=0.
   - From t+8: rd_valid=1 again; no further writes.
6. Reset mid-operation: 3 entries queued and reads in flight; assert resetn=0 for 1 cycle.
   - Following cycles: no mem_we, rd_valid=0, fifo_count=0.
   - The next push after reset is written normally.
